cpu_run_ctrl: RTL and testbench

Run/halt/single-step sequencer for the uCISC CPU core on the TinyFPGA board. It divides the board clock into a one-cycle CPU clock-enable and debounces the run and step push-buttons. It also halts the core cleanly at instruction boundaries, either on request or on a PC breakpoint. It sits between the board pins and the CPU's clock input, and watches the CPU's step and PC peek outputs.

---
 rtl/cpu_run_ctrl_if.sv | 22 ++
 rtl/cpu_run_ctrl.sv | 167 ++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_if.sv
// CPU-side bus of the run controller: breakpoint setup, CPU peeks and the
// advance strobe / status going back out.
interface cpu_run_ctrl_if;
  logic        cpu_clock_en;
  logic [1:0]  state;
  logic        halted;
  logic        break_hit;
  logic [15:0] pc;
  logic [1:0]  cpu_step;
  logic        break_enable;
  logic [15:0] break_addr;

  modport master (
    input  pc, cpu_step, break_enable, break_addr,
    output cpu_clock_en, state, halted, break_hit
  );

  modport slave (
    output pc, cpu_step, break_enable, break_addr,
    input  cpu_clock_en, state, halted, break_hit
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer: prescaled CPU clock-enable, debounced
// run/step buttons and instruction-boundary halting with a PC breakpoint.

module cpu_run_ctrl_btn #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          prev_q, prev_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      prev_q  <= prev_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count consecutive samples that disagree with the accepted level; any
  // agreeing sample restarts the count.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q >= CNT_LAST) level_d = sync2_q;
      else                   cnt_d   = cnt_q + 1'b1;
    end
    prev_d  = level_q;
    press_d = level_q & ~prev_q;
  end

  assign press = press_q;
endmodule

module cpu_run_ctrl #(
  parameter int DIV_WIDTH       = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit START_RUNNING   = 1'b1
) (
  input  logic          clock_input,
  input  logic          reset,
  input  logic          run_btn,
  input  logic          step_btn,
  cpu_run_ctrl_if.master bus
);
  typedef enum logic [1:0] {
    HALT = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10
  } run_state_e;

  localparam int         NUM_BTN     = 2;
  localparam int         BTN_RUN     = 0;
  localparam int         BTN_STEP    = 1;
  localparam run_state_e RESET_STATE = START_RUNNING ? RUN : HALT;

  logic [NUM_BTN-1:0] btn_raw, btn_press;
  assign btn_raw = {step_btn, run_btn};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    cpu_run_ctrl_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk     (clock_input),
      .rst_n   (reset),
      .btn_raw (btn_raw[g]),
      .press   (btn_press[g])
    );
  end

  run_state_e           st_q, st_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 en_q, en_d;
  logic                 sample_q, sample_d;
  logic                 at_bnd_q, at_bnd_d;
  logic                 brk_q, brk_d;

  logic tick, run_press, step_press, boundary_now, at_bnd_eff, bp_hit;

  always_ff @(posedge clock_input or negedge reset) begin
    if (!reset) begin
      st_q     <= RESET_STATE;
      div_q    <= '0;
      en_q     <= 1'b0;
      sample_q <= 1'b0;
      at_bnd_q <= 1'b1;
      brk_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      div_q    <= div_d;
      en_q     <= en_d;
      sample_q <= sample_d;
      at_bnd_q <= at_bnd_d;
      brk_q    <= brk_d;
    end
  end

  assign tick         = &div_q;
  assign run_press    = btn_press[BTN_RUN];
  assign step_press   = btn_press[BTN_STEP];
  assign boundary_now = (bus.cpu_step == 2'b00);
  // In the sample cycle the live phase is fresher than the stored flag.
  assign at_bnd_eff   = sample_q ? boundary_now : at_bnd_q;
  assign bp_hit       = sample_q && boundary_now && bus.break_enable &&
                        (bus.pc == bus.break_addr);

  always_comb begin
    st_d     = st_q;
    brk_d    = brk_q;
    div_d    = div_q + 1'b1;
    sample_d = en_q;
    at_bnd_d = at_bnd_eff;
    case (st_q)
      HALT: begin
        if (run_press) begin
          st_d  = RUN;
          brk_d = 1'b0;
        end else if (step_press) begin
          st_d = STEP;
        end
      end
      RUN: begin
        if (bp_hit) begin
          st_d  = HALT;
          brk_d = 1'b1;
        end else if (run_press) begin
          st_d = at_bnd_eff ? HALT : STEP;
        end
      end
      STEP: begin
        // Breakpoint deliberately not checked so the core can step off it.
        if (sample_q && boundary_now) st_d = HALT;
      end
      default: st_d = HALT;
    endcase
  end

  // Gate on the next state so the cycle after entering HALT never enables.
  always_comb begin
    en_d             = tick && (st_d != HALT);
    bus.cpu_clock_en = en_q;
    bus.state        = st_q;
    bus.halted       = (st_q == HALT);
    bus.break_hit    = brk_q;
  end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a behavioural CPU model with per-instruction phase
// counts, fixed scenarios and randomized breakpoint runs.
module tb_cpu_run_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run_btn = 1'b0;
  logic step_btn = 1'b0;
  logic brk_en = 1'b0;
  logic [15:0] brk_addr = 16'h0;

  always #5 clk = ~clk;

  cpu_run_ctrl_if bus();

  cpu_run_ctrl #(.DIV_WIDTH(2), .DEBOUNCE_CYCLES(4), .START_RUNNING(1'b1)) dut (
    .clock_input (clk),
    .reset       (rst_n),
    .run_btn     (run_btn),
    .step_btn    (step_btn),
    .bus         (bus)
  );

  // CPU model: instruction i takes lens[i] enables; phase 0 is the boundary.
  logic        model_en = 1'b0;
  logic        model_load = 1'b0;
  logic [15:0] load_pc = 16'h0;
  logic [15:0] m_pc = 16'h0;
  logic [1:0]  m_ph = 2'd0;
  int          m_idx = 0;
  int          lens[16];
  int          en_count = 0;

  always @(posedge clk) begin
    if (bus.cpu_clock_en) en_count <= en_count + 1;
    if (model_load) begin
      m_pc  <= load_pc;
      m_ph  <= 2'd0;
      m_idx <= 0;
    end else if (model_en && bus.cpu_clock_en) begin
      if (int'(m_ph) + 1 >= lens[m_idx]) begin
        m_ph  <= 2'd0;
        m_pc  <= m_pc + 16'd1;
        m_idx <= (m_idx + 1) % 16;
      end else begin
        m_ph <= m_ph + 2'd1;
      end
    end
  end

  assign bus.pc           = m_pc;
  assign bus.cpu_step     = m_ph;
  assign bus.break_enable = brk_en;
  assign bus.break_addr   = brk_addr;

  int n_cmp = 0;
  int n_err = 0;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fixed_lens();
    for (int i = 0; i < 16; i++) lens[i] = 4;
  endtask

  task automatic do_reset(input logic [15:0] pc0, input logic men);
    @(negedge clk);
    rst_n = 1'b0;
    model_en = 1'b0;
    load_pc = pc0;
    model_load = 1'b1;
    @(negedge clk);
    model_load = 1'b0;
    model_en = men;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.state === s) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic setup_break(input logic [15:0] start, input logic [15:0] addr);
    brk_en = 1'b1;
    brk_addr = addr;
    do_reset(start, 1'b1);
  endtask

  task automatic test_reset();
    int first, prev, npulse;
    fixed_lens();
    brk_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_en = 1'b0;
    load_pc = 16'h0;
    model_load = 1'b1;
    @(negedge clk);
    model_load = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.cpu_clock_en !== 1'b0) begin n_err++; $display("FAIL rst_en: got %b want 0", bus.cpu_clock_en); end
    n_cmp++; if (bus.state !== 2'b01) begin n_err++; $display("FAIL rst_state: got %b want 01", bus.state); end
    n_cmp++; if (bus.halted !== 1'b0) begin n_err++; $display("FAIL rst_halted: got %b want 0", bus.halted); end
    n_cmp++; if (bus.break_hit !== 1'b0) begin n_err++; $display("FAIL rst_brk: got %b want 0", bus.break_hit); end
    rst_n = 1'b1;
    first = -1; prev = -1; npulse = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (bus.cpu_clock_en === 1'b1) begin
        npulse++;
        if (first < 0) first = i;
        else begin
          n_cmp++; if (i - prev != 4) begin n_err++; $display("FAIL en_period: got %0d want 4", i - prev); end
        end
        prev = i;
      end
    end
    n_cmp++; if (first < 1 || first > 5) begin n_err++; $display("FAIL en_first: got %0d want 1..5", first); end
    n_cmp++; if (npulse < 5) begin n_err++; $display("FAIL en_count: got %0d want >=5", npulse); end
    n_cmp++; if (bus.state !== 2'b01) begin n_err++; $display("FAIL run_state: got %b want 01", bus.state); end
    n_cmp++; if (bus.break_hit !== 1'b0) begin n_err++; $display("FAIL run_brk: got %b want 0", bus.break_hit); end
  endtask

  task automatic test_breakpoint();
    bit ok;
    int e0;
    fixed_lens();
    setup_break(16'h000E, 16'h0010);
    e0 = en_count;
    wait_state(2'b00, 200, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_timeout: state %b want 00", bus.state); end
    n_cmp++; if (bus.break_hit !== 1'b1) begin n_err++; $display("FAIL bp_hit: got %b want 1", bus.break_hit); end
    n_cmp++; if (bus.halted !== 1'b1) begin n_err++; $display("FAIL bp_halted: got %b want 1", bus.halted); end
    n_cmp++; if (m_pc !== 16'h0010 || m_ph !== 2'd0) begin n_err++; $display("FAIL bp_pc: got %h/%0d want 0010/0", m_pc, m_ph); end
    n_cmp++; if (en_count - e0 != 8) begin n_err++; $display("FAIL bp_enables: got %0d want 8", en_count - e0); end
    cycles(20);
    n_cmp++; if (en_count - e0 != 8) begin n_err++; $display("FAIL bp_quiet: got %0d want 8", en_count - e0); end
  endtask

  task automatic test_step_off();
    bit ok;
    int e0;
    e0 = en_count;
    step_btn = 1'b1;
    wait_state(2'b10, 20, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL step_enter: state %b want 10", bus.state); end
    step_btn = 1'b0;
    wait_state(2'b00, 80, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL step_done: state %b want 00", bus.state); end
    n_cmp++; if (en_count - e0 != 4) begin n_err++; $display("FAIL step_enables: got %0d want 4", en_count - e0); end
    n_cmp++; if (m_pc !== 16'h0011) begin n_err++; $display("FAIL step_pc: got %h want 0011", m_pc); end
    cycles(12);
    n_cmp++; if (bus.break_hit !== 1'b1) begin n_err++; $display("FAIL step_brk_sticky: got %b want 1", bus.break_hit); end
    n_cmp++; if (en_count - e0 != 4) begin n_err++; $display("FAIL step_quiet: got %0d want 4", en_count - e0); end
  endtask

  task automatic test_run_press();
    bit ok;
    int e0;
    run_btn = 1'b1;
    wait_state(2'b01, 20, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL resume: state %b want 01", bus.state); end
    n_cmp++; if (bus.break_hit !== 1'b0) begin n_err++; $display("FAIL resume_brk_clr: got %b want 0", bus.break_hit); end
    run_btn = 1'b0;
    cycles(12);
    run_btn = 1'b1;
    cycles(3);
    run_btn = 1'b0;
    cycles(15);
    n_cmp++; if (bus.state !== 2'b01) begin n_err++; $display("FAIL glitch: state %b want 01", bus.state); end
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (m_ph === 2'd2) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    model_en = 1'b0;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL phase2_timeout: got %0d want 2", m_ph); end
    run_btn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (bus.state !== 2'b01) break;
      @(negedge clk);
    end
    n_cmp++; if (bus.state !== 2'b10) begin n_err++; $display("FAIL mid_instr_press: state %b want 10", bus.state); end
    run_btn = 1'b0;
    e0 = en_count;
    cycles(12);
    n_cmp++; if (bus.state !== 2'b10 || en_count == e0) begin n_err++; $display("FAIL step_wait: state %b enables %0d want 10 and >0", bus.state, en_count - e0); end
    model_en = 1'b1;
    e0 = en_count;
    wait_state(2'b00, 40, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL finish_instr: state %b want 00", bus.state); end
    n_cmp++; if (m_ph !== 2'd0 || en_count - e0 != 2) begin n_err++; $display("FAIL finish_enables: phase %0d enables %0d want 0/2", m_ph, en_count - e0); end
    cycles(12);
    n_cmp++; if (en_count - e0 != 2) begin n_err++; $display("FAIL finish_quiet: got %0d want 2", en_count - e0); end
  endtask

  task automatic test_run_step_same();
    run_btn = 1'b1;
    step_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.state !== 2'b00) break;
      @(negedge clk);
    end
    n_cmp++; if (bus.state !== 2'b01) begin n_err++; $display("FAIL both_press: state %b want 01", bus.state); end
    cycles(5);
    run_btn = 1'b0;
    step_btn = 1'b0;
    cycles(15);
    n_cmp++; if (bus.state !== 2'b01) begin n_err++; $display("FAIL both_press_hold: state %b want 01", bus.state); end
  endtask

  task automatic test_reset_mid_step();
    bit ok;
    fixed_lens();
    setup_break(16'h000E, 16'h0010);
    wait_state(2'b00, 200, ok);
    step_btn = 1'b1;
    wait_state(2'b10, 20, ok);
    step_btn = 1'b0;
    n_cmp++; if (!ok || bus.break_hit !== 1'b1) begin n_err++; $display("FAIL mid_setup: state %b brk %b want 10/1", bus.state, bus.break_hit); end
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.cpu_clock_en === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if (!ok) begin n_err++; $display("FAIL mid_en_timeout: got %b want 1", bus.cpu_clock_en); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.cpu_clock_en !== 1'b0) begin n_err++; $display("FAIL async_en: got %b want 0", bus.cpu_clock_en); end
    n_cmp++; if (bus.break_hit !== 1'b0) begin n_err++; $display("FAIL async_brk: got %b want 0", bus.break_hit); end
    n_cmp++; if (bus.state !== 2'b01) begin n_err++; $display("FAIL async_state: got %b want 01", bus.state); end
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);
    n_cmp++; if (bus.state !== 2'b01) begin n_err++; $display("FAIL post_rst_state: got %b want 01", bus.state); end
  endtask

  task automatic test_resume_at_break();
    fixed_lens();
    setup_break(16'h0040, 16'h0040);
    cycles(40);
    n_cmp++; if (bus.state !== 2'b01 || m_pc === 16'h0040) begin n_err++; $display("FAIL start_on_bp: state %b pc %h want 01 and pc moved", bus.state, m_pc); end
  endtask

  task automatic test_random_break();
    bit ok;
    int e0, k, expect_en;
    logic [15:0] start, addr;
    for (int it = 0; it < 6; it++) begin
      for (int j = 0; j < 16; j++) lens[j] = int'($urandom_range(1, 4));
      start = 16'($urandom);
      k = int'($urandom_range(1, 5));
      addr = start + 16'(k);
      expect_en = 0;
      for (int j = 0; j < k; j++) expect_en += lens[j];
      setup_break(start, addr);
      e0 = en_count;
      wait_state(2'b00, 4 * expect_en + 40, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rnd_timeout[%0d]: state %b want 00", it, bus.state); end
      n_cmp++; if (en_count - e0 != expect_en || m_pc !== addr) begin n_err++; $display("FAIL rnd_bp[%0d]: enables %0d pc %h want %0d/%h", it, en_count - e0, m_pc, expect_en, addr); end
      n_cmp++; if (bus.break_hit !== 1'b1) begin n_err++; $display("FAIL rnd_brk[%0d]: got %b want 1", it, bus.break_hit); end
    end
  endtask

  initial begin
    fixed_lens();
    test_reset();
    test_breakpoint();
    test_step_off();
    test_run_press();
    test_run_step_same();
    test_reset_mid_step();
    test_resume_at_break();
    test_random_break();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
